// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the instruction/data memory arbiter.
//   - arb_state_e : arbiter FSM states (2-bit encoding)
//   - arb_owner_e : which requester owns the memory bus
//   - busOwner()  : maps a bus state onto its owner
//   - STARVE_CNT_W: width of the optional starvation counter
//     (only used when ARB_STARVE_GUARD_EN is defined)
package mem_arbiter_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUS_I = 2'd1,
    ARB_BUS_D = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

  // Only BUS_D belongs to the data port; every other state is treated as
  // the fetch side, which is all the caller needs when completing a
  // transfer from one of the two bus states.
  function automatic arb_owner_e busOwner(input arb_state_e s);
    return (s == ARB_BUS_D) ? ARB_OWN_D : ARB_OWN_I;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt
//   Counts consecutive data-port grants made while a fetch is waiting,
//   and flags when that count reaches STARVE_MAX so the arbiter can hand
//   the next slot to the fetch port. Instantiated by mem_arbiter only
//   when ARB_STARVE_GUARD_EN is defined.
// Ports
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   eval_i     in  arbiter is in IDLE this cycle (arbitration cycle)
//   if_req_i   in  fetch request as seen by the arbiter
//   d_grant_i  in  data port is being granted this cycle
//   at_max_o   out counter has reached STARVE_MAX
module arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic eval_i,
  input  logic if_req_i,
  input  logic d_grant_i,
  output logic at_max_o
);

  logic [STARVE_CNT_W-1:0] starveCnt_q;

  // The counter only moves in arbitration cycles. A D grant while a fetch
  // is pending bumps it; anything else seen in IDLE (no fetch waiting, or
  // the fetch itself winning) wipes the history. STARVE_MAX is capped at
  // 15 so the count can never wrap before the fetch is forced through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt_q <= '0;
    end else if (eval_i) begin
      if (if_req_i && d_grant_i) begin
        starveCnt_q <= starveCnt_q + 1'b1;
      end else begin
        starveCnt_q <= '0;
      end
    end
  end

  assign at_max_o = (starveCnt_q == STARVE_CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported, variable-latency memory between the fetch
//   port (I, read-only) and the data port (D, read/write). D has fixed
//   priority. Each transfer runs IDLE -> BUS_x -> RESP -> IDLE, so the
//   fastest req-to-ack turnaround is three cycles.
//   Optional feature macro: ARB_STARVE_GUARD_EN. When defined, a fetch
//   that has watched STARVE_MAX consecutive D grants is granted next.
// Ports
//   clk, rst_n                 clock / asynchronous active-low reset
//   if_req, if_addr            fetch request and address (held until ack)
//   if_rdata, if_ack           fetch read data and one-cycle completion
//   d_req, d_wen, d_addr,
//   d_wdata                    data request (held until ack)
//   d_rdata, d_ack             data read data (kept on writes), completion
//   m_req, m_wen, m_addr,
//   m_wdata                    registered memory request
//   m_rdata, m_ack             memory response (m_ack used only in BUS_x)
//   busy                       high whenever the FSM is not in IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : gBadStarveMax
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

  arb_state_e        state_q;
  logic              mReq_q;
  logic              mWen_q;
  logic [ADDR_W-1:0] mAddr_q;
  logic [DATA_W-1:0] mWdata_q;
  logic [DATA_W-1:0] ifRdata_q;
  logic [DATA_W-1:0] dRdata_q;
  logic              ifAck_q;
  logic              dAck_q;
  logic              busy_q;

  logic isIdle;
  logic guardForceI;
  logic grantD;
  logic grantI;

  assign isIdle = (state_q == ARB_IDLE);

`ifdef ARB_STARVE_GUARD_EN
  logic starveAtMax;

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .eval_i   (isIdle),
    .if_req_i (if_req),
    .d_grant_i(grantD),
    .at_max_o (starveAtMax)
  );

  assign guardForceI = starveAtMax & if_req;
`else
  assign guardForceI = 1'b0;
`endif

  // Grants are only meaningful in IDLE; D wins unless the guard has
  // decided the waiting fetch has been starved long enough.
  assign grantD = isIdle & d_req & ~guardForceI;
  assign grantI = isIdle & if_req & ~grantD;

  // Single registered FSM. Every output is a flop so the memory side sees
  // clean, glitch-free request signals. The ack pulse is raised on the
  // same edge that enters RESP, so it lives exactly for the RESP cycle.
  // A reset abandons any transfer in flight; the memory is expected to
  // tolerate m_req falling without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      mReq_q    <= 1'b0;
      mWen_q    <= 1'b0;
      mAddr_q   <= '0;
      mWdata_q  <= '0;
      ifRdata_q <= '0;
      dRdata_q  <= '0;
      ifAck_q   <= 1'b0;
      dAck_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grantD) begin
            state_q  <= ARB_BUS_D;
            mReq_q   <= 1'b1;
            mWen_q   <= d_wen;
            mAddr_q  <= d_addr;
            mWdata_q <= d_wdata;
            busy_q   <= 1'b1;
          end else if (grantI) begin
            state_q <= ARB_BUS_I;
            mReq_q  <= 1'b1;
            mWen_q  <= 1'b0;
            mAddr_q <= if_addr;
            busy_q  <= 1'b1;
          end
        end
        ARB_BUS_I, ARB_BUS_D: begin
          if (m_ack) begin
            state_q <= ARB_RESP;
            mReq_q  <= 1'b0;
            if (busOwner(state_q) == ARB_OWN_D) begin
              dAck_q <= 1'b1;
              if (!mWen_q) begin
                dRdata_q <= m_rdata;
              end
            end else begin
              ifAck_q   <= 1'b1;
              ifRdata_q <= m_rdata;
            end
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
          ifAck_q <= 1'b0;
          dAck_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign m_req    = mReq_q;
  assign m_wen    = mWen_q;
  assign m_addr   = mAddr_q;
  assign m_wdata  = mWdata_q;
  assign if_rdata = ifRdata_q;
  assign d_rdata  = dRdata_q;
  assign if_ack   = ifAck_q;
  assign d_ack    = dAck_q;
  assign busy     = busy_q;

endmodule
